// File: rtl/latch_sched_pkg.sv
// Shared definitions for the latch bank scheduler: FSM encoding, counter width, latch timing.
// Latency: n/a (package).
// Backpressure: n/a (package).
`timescale 1ns/1ps
package latch_sched_pkg;

  // Write sequencing phases; encoding is fixed so external tools can decode it.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_GATE  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Gate counter width; GATE_CYCLES is limited to 1..15 by this.
  localparam int CNT_W = 4;

  // Latch propagation delays in ns (D to Q, D to Qn), for timing models.
  localparam int LAT_Q_DLY  = 14;
  localparam int LAT_QN_DLY = 21;

endpackage

// File: rtl/latch_bank_scheduler_rr_arbiter.sv
// Round-robin pick: first set request above ptr, wrapping; returns one-hot grant and index.
// Latency: combinational, zero cycles; the pointer register lives in the parent.
// Backpressure: none; any=0 when no request is set.
// Ports: req (requests), ptr (last winner) -> gnt (one-hot), idx (winner index), any (a winner exists).
`timescale 1ns/1ps
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    // Scan ptr+1 .. ptr+NREQ, so the previous winner is considered last.
    for (int i = 1; i <= NREQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!any && req[cand[IDX_W-1:0]]) begin
        any                    = 1'b1;
        gnt[cand[IDX_W-1:0]]   = 1'b1;
        idx                    = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/latch_bank_scheduler.sv
// Arbitrates NREQ writers onto a bank of gated D latches, sequencing SETUP, GATE, HOLD, DONE.
// Latency: REQ sample to ACK = GATE_CYCLES+3 edges (ERR after 2 edges); one write per GATE_CYCLES+4 cycles.
// Backpressure: REQ is a level held until ACK/ERR; losers simply wait while BUSY, nothing is dropped.
// Ports: CLK/RST (sync, active-high); REQ/WDATA/WADDR per requester; GNT/ACK/ERR one-hot per
// requester; LAT_D/LAT_EN drive the latch bank D and per-entry gates; BUSY = not idle.
`timescale 1ns/1ps
module latch_bank_scheduler
  import latch_sched_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int WIDTH       = 1,
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 2,
  parameter int GATE_CYCLES = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          REQ,
  input  logic [NREQ*WIDTH-1:0]    WDATA,
  input  logic [NREQ*ADDR_W-1:0]   WADDR,
  output logic [NREQ-1:0]          GNT,
  output logic [NREQ-1:0]          ACK,
  output logic [NREQ-1:0]          ERR,
  output logic [WIDTH-1:0]         LAT_D,
  output logic [DEPTH-1:0]         LAT_EN,
  output logic                     BUSY
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [WIDTH-1:0]  wdata_arr [NREQ];
  logic [ADDR_W-1:0] waddr_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign wdata_arr[gi] = WDATA[gi*WIDTH +: WIDTH];
    assign waddr_arr[gi] = WADDR[gi*ADDR_W +: ADDR_W];
  end

  logic [NREQ-1:0]  arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;

  state_t            state_q,    state_d;
  logic [IDX_W-1:0]  ptr_q,      ptr_d;
  logic [WIDTH-1:0]  data_q,     data_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [NREQ-1:0]   win_q,      win_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              err_flag_q, err_flag_d;
  logic [NREQ-1:0]   gnt_q,      gnt_d;
  logic [NREQ-1:0]   ack_q,      ack_d;
  logic [NREQ-1:0]   err_q,      err_d;
  logic [DEPTH-1:0]  lat_en_q,   lat_en_d;
  logic              busy_q,     busy_d;
  logic              addr_ok;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req (REQ),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign addr_ok = (32'(addr_q) < 32'(DEPTH));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    data_d     = data_q;
    addr_d     = addr_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    err_flag_d = err_flag_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          ptr_d      = arb_idx;
          win_d      = arb_gnt;
          data_d     = wdata_arr[arb_idx];
          addr_d     = waddr_arr[arb_idx];
          err_flag_d = 1'b0;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (addr_ok) begin
          state_d = ST_GATE;
          cnt_d   = CNT_W'(GATE_CYCLES - 1);
        end else begin
          // Out-of-range target: skip the gate entirely and report an error.
          state_d    = ST_DONE;
          err_flag_d = 1'b1;
        end
      end
      ST_GATE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so every output pin is a flop;
    // LAT_EN therefore only ever changes on a clock edge.
    gnt_d    = (state_d != ST_IDLE) ? win_d : '0;
    lat_en_d = (state_d == ST_GATE) ? (DEPTH'(1) << addr_d) : '0;
    ack_d    = (state_d == ST_DONE && !err_flag_d) ? win_d : '0;
    err_d    = (state_d == ST_DONE &&  err_flag_d) ? win_d : '0;
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      ptr_q      <= IDX_W'(NREQ - 1);
      data_q     <= '0;
      addr_q     <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
      err_flag_q <= 1'b0;
      gnt_q      <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      lat_en_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      err_flag_q <= err_flag_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      lat_en_q   <= lat_en_d;
      busy_q     <= busy_d;
    end
  end

  assign GNT    = gnt_q;
  assign ACK    = ack_q;
  assign ERR    = err_q;
  assign LAT_D  = data_q;
  assign LAT_EN = lat_en_q;
  assign BUSY   = busy_q;

endmodule

// File: doc/latch_bank_scheduler.md
Name: latch_bank_scheduler

Overview:
- Shares a bank of DEPTH clocked D latches (WIDTH bits each, one gate input per entry) between NREQ write requesters.
- Grants requesters round-robin and captures each winner's data and address.
- Sequences the latch gate through setup, gate, hold and acknowledge phases, so latch D is stable before, during and after the transparent window. This covers the latch's 14 ns Q and 21 ns Qn propagation.
- Sits between requester logic and the latch bank; the latch bank itself is unchanged.

Parameters:
- NREQ, 2, number of requesters (2..8).
- WIDTH, 1, data bits per latch entry.
- DEPTH, 4, number of latch entries.
- ADDR_W, 2, address width; an address is valid when it is less than DEPTH.
- GATE_CYCLES, 2, CLK cycles the gate is held high (1..15). The gate window must exceed 21 ns, so with the 60 ns CLK period the minimum is 1.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  reset, synchronous, active-high.
- REQ  in  NREQ  per-requester write request; level, held until ACK or ERR.
- WDATA  in  NREQ*WIDTH  per-requester write data; requester i uses slice [i*WIDTH +: WIDTH].
- WADDR  in  NREQ*ADDR_W  per-requester target address; requester i uses slice [i*ADDR_W +: ADDR_W].
- GNT  out  NREQ  one-hot grant; high from SETUP through ACK.
- ACK  out  NREQ  one-hot, 1-cycle pulse when the write is complete.
- ERR  out  NREQ  one-hot, 1-cycle pulse when the address is out of range (no latch write).
- LAT_D  out  WIDTH  data driven to the latch bank D inputs.
- LAT_EN  out  DEPTH  per-entry latch gate (latch CLK); at most one bit high.
- BUSY  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; captured data/address 0; round-robin pointer NREQ-1, so requester 0 wins first.
- States: IDLE, SETUP, GATE, HOLD, DONE.
- IDLE:
  - If REQ is nonzero, pick the first set bit searching from pointer+1 upward with wrap.
  - Capture that requester's WDATA/WADDR into internal registers, update the pointer to the winner, go to SETUP.
  - Otherwise stay in IDLE.
- SETUP (1 cycle): GNT[winner]=1, LAT_D=captured data, LAT_EN all 0.
  - Valid address: go to GATE and load the gate counter with GATE_CYCLES-1.
  - Invalid address (addr >= DEPTH): go to DONE and flag an error.
- GATE (GATE_CYCLES cycles): LAT_EN[addr]=1, LAT_D stable. Decrement the counter; at 0 go to HOLD.
- HOLD (1 cycle): LAT_EN all 0, LAT_D still stable (hold margin).
- DONE (1 cycle):
  - ACK[winner]=1, or ERR[winner]=1 if the error is flagged.
  - GNT[winner] is still 1.
  - Next state is IDLE.
  - LAT_D keeps its last value until the next capture.
- Latency, REQ sampled in IDLE to ACK high:
  - Valid address: GATE_CYCLES+3 edges.
  - Invalid address: 2 edges.
  - Back-to-back: a new arbitration happens on the IDLE cycle after DONE, so requests are serviced every GATE_CYCLES+4 cycles.
- All outputs are registered. LAT_EN changes only on CLK edges, so the gates are glitch-free.
- A requester dropping REQ after grant does not abort the write; ACK is still pulsed. WDATA/WADDR changes after capture are ignored.
- REQ from a non-granted requester while BUSY: waits, no loss.
- Simultaneous requests: strict round-robin. With every requester continuously requesting, each is served once per NREQ transactions.
- RST mid-operation: on the sampled edge LAT_EN drops to 0 and GNT/ACK/ERR clear, with no ACK for the aborted write. The latch content is undefined for an aborted GATE.
- RST has priority over all transitions.

Decomposition:
- Package latch_sched_pkg holds:
  - the state encoding (IDLE=0, SETUP=1, GATE=2, HOLD=3, DONE=4; 3 bits);
  - the gate counter width constant (4 bits);
  - the latch timing constants LAT_Q_DLY=14 and LAT_QN_DLY=21 (ns), used by benches.
- One natural sub-module: rr_arbiter. It takes REQ and the pointer and returns a one-hot winner plus its index; it is combinational, with the pointer register in the parent.

Test Plan (NREQ=2, WIDTH=1, DEPTH=4, GATE_CYCLES=2, CLK half-period 30 ns):
- Reset: RST high 2 cycles with REQ=2'b11 -> all outputs 0, BUSY=0. After release, requester 0 is granted first.
- Single write: REQ=01, WDATA[0]=1, WADDR[0]=2 ->
  - GNT=01 from the next edge;
  - LAT_EN=0100 for exactly 2 cycles after SETUP;
  - LAT_D=1 from SETUP through DONE;
  - ACK=01 on the 5th edge;
  - latch entry 2: Q=1 14 ns and Qn=0 21 ns after the LAT_EN rise.
- Contention: REQ=11 held, req0 writes 0 to addr1, req1 writes 1 to addr3 ->
  - grants alternate 01, 10, 01, ...;
  - LAT_EN alternates 0010 and 1000;
  - ACKs are 6 cycles apart.
- Out of range (DEPTH=3 build): WADDR[0]=3 -> LAT_EN never rises; ERR=01 pulse 2 edges after the REQ sample; no ACK.
- Mid-write reset: RST asserted during the 1st GATE cycle -> LAT_EN=0 on the next edge, no ACK, state IDLE, pointer back to NREQ-1.
- Early REQ drop: REQ[1] deasserted in GATE -> the write completes and ACK=10 still pulses. WDATA[1] changed in GATE -> LAT_D unchanged.
